// File: rtl/inv_permute_unit_pkg.sv
// Shared constants, FSM encoding and flat-address helper for the inverse-pi unit.
// State geometry: x = row (0..4), y = column (0..4), z = page (0..63);
// flat bit index = z*25 + y*5 + x.
package inv_permute_unit_pkg;

    localparam int unsigned NUM_ROW        = 5;
    localparam int unsigned NUM_COLUMN     = 5;
    localparam int unsigned NUM_PAGE       = 64;
    localparam int unsigned CELLS_PER_PAGE = NUM_ROW * NUM_COLUMN;
    localparam int unsigned NUM_CELLS      = CELLS_PER_PAGE * NUM_PAGE;
    localparam int unsigned LEN_ADDRESS    = 11;

    localparam int unsigned ROW_W  = 3;
    localparam int unsigned COL_W  = 3;
    localparam int unsigned PAGE_W = 6;
    // Wide enough for x + 3*y (max 16) so the mod-5 sees the untruncated sum.
    localparam int unsigned MOD_W  = 5;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROW - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLUMN - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGE - 1);

    typedef enum logic [1:0] {
        INV_IDLE = 2'd0,
        INV_RUN  = 2'd1,
        INV_DONE = 2'd2
    } inv_state_e;

    // Flat bit index of cell (row, col, page).
    function automatic logic [LEN_ADDRESS-1:0] flat_addr(
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col,
        input logic [PAGE_W-1:0] page
    );
        return LEN_ADDRESS'(page) * LEN_ADDRESS'(CELLS_PER_PAGE)
             + LEN_ADDRESS'(col)  * LEN_ADDRESS'(NUM_ROW)
             + LEN_ADDRESS'(row);
    endfunction

endpackage

// File: rtl/inv_permute_unit_inv_pi_addr.sv
// Combinational inverse-pi destination address.
// Ports: x_i/y_i/z_i source cell coordinates; dst_addr_c_o flat index of
// out(row=(x+3y)%5, col=x, page=z).
module inv_permute_unit_inv_pi_addr
    import inv_permute_unit_pkg::*;
(
    input  logic [ROW_W-1:0]       x_i,
    input  logic [COL_W-1:0]       y_i,
    input  logic [PAGE_W-1:0]      z_i,
    output logic [LEN_ADDRESS-1:0] dst_addr_c_o
);

    logic [MOD_W-1:0] sum;
    logic [MOD_W-1:0] row;

    always_comb begin
        sum          = MOD_W'(x_i) + MOD_W'(3) * MOD_W'(y_i);
        row          = sum % MOD_W'(NUM_ROW);
        dst_addr_c_o = flat_addr(ROW_W'(row), COL_W'(x_i), z_i);
    end

endmodule

// File: rtl/inv_permute_unit.sv
// Inverse Keccak pi step: walks the 5x5x64 state and scatters each source cell
// to its inverse-pi position in the output register.
// Ports: clk; rst async active-low; start (1-cycle pulse, IDLE only);
// data_in (held stable while busy); busy (high during RUN); done (1-cycle
// pulse, result valid); data_out (result, held until next accepted start).
// Build option: INV_PERMUTE_LANE_EN moves a whole 64-bit lane per cycle
// (25 RUN cycles) instead of one bit per cycle (1600 RUN cycles).
module inv_permute_unit
    import inv_permute_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] data_in,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CELLS-1:0] data_out
);

    inv_state_e           state_q, state_d;
    logic [ROW_W-1:0]     x_q, x_d;
    logic [COL_W-1:0]     y_q, y_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_CELLS-1:0] data_out_q, data_out_d;

    logic [LEN_ADDRESS-1:0] src_addr;
    logic [LEN_ADDRESS-1:0] dst_addr;
    logic                   last_cell;

`ifdef INV_PERMUTE_LANE_EN
    // Lane mode: addresses computed for page 0 and offset per page below.
    assign src_addr  = flat_addr(x_q, y_q, PAGE_W'(0));
    assign last_cell = (x_q == ROW_LAST) && (y_q == COL_LAST);

    inv_permute_unit_inv_pi_addr u_addr (
        .x_i          (x_q),
        .y_i          (y_q),
        .z_i          (PAGE_W'(0)),
        .dst_addr_c_o (dst_addr)
    );
`else
    logic [PAGE_W-1:0] z_q, z_d;

    assign src_addr  = flat_addr(x_q, y_q, z_q);
    assign last_cell = (x_q == ROW_LAST) && (y_q == COL_LAST) && (z_q == PAGE_LAST);

    inv_permute_unit_inv_pi_addr u_addr (
        .x_i          (x_q),
        .y_i          (y_q),
        .z_i          (z_q),
        .dst_addr_c_o (dst_addr)
    );
`endif

    // Next-state, counter chain and output-register update.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
`ifndef INV_PERMUTE_LANE_EN
        z_d        = z_q;
`endif
        busy_d     = 1'b0;
        done_d     = 1'b0;
        data_out_d = data_out_q;

        case (state_q)
            INV_IDLE: begin
                if (start) begin
                    state_d    = INV_RUN;
                    busy_d     = 1'b1;
                    data_out_d = '0;
                    x_d        = '0;
                    y_d        = '0;
`ifndef INV_PERMUTE_LANE_EN
                    z_d        = '0;
`endif
                end
            end
            INV_RUN: begin
                busy_d = 1'b1;
`ifdef INV_PERMUTE_LANE_EN
                for (int unsigned z = 0; z < NUM_PAGE; z++) begin
                    data_out_d[dst_addr + LEN_ADDRESS'(z * CELLS_PER_PAGE)] =
                        data_in[src_addr + LEN_ADDRESS'(z * CELLS_PER_PAGE)];
                end
`else
                data_out_d[dst_addr] = data_in[src_addr];
`endif
                // x fastest, carry into y, then z; all wrap to 0 after the last cell.
                if (x_q == ROW_LAST) begin
                    x_d = '0;
                    if (y_q == COL_LAST) begin
                        y_d = '0;
`ifndef INV_PERMUTE_LANE_EN
                        z_d = (z_q == PAGE_LAST) ? '0 : z_q + PAGE_W'(1);
`endif
                    end else begin
                        y_d = y_q + COL_W'(1);
                    end
                end else begin
                    x_d = x_q + ROW_W'(1);
                end
                if (last_cell) begin
                    state_d = INV_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            INV_DONE: begin
                state_d = INV_IDLE;
            end
            default: begin
                state_d = INV_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INV_IDLE;
            x_q        <= '0;
            y_q        <= '0;
`ifndef INV_PERMUTE_LANE_EN
            z_q        <= '0;
`endif
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
`ifndef INV_PERMUTE_LANE_EN
            z_q        <= z_d;
`endif
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_inv_permute_unit.sv
// Self-checking bench for inv_permute_unit (bit-serial or INV_PERMUTE_LANE_EN build).
module tb_inv_permute_unit;

    localparam int NC = 1600;
`ifdef INV_PERMUTE_LANE_EN
    localparam int LAT      = 25;
    localparam int ABORT_AT = 12;
    localparam int N_RAND   = 100;
`else
    localparam int LAT      = 1600;
    localparam int ABORT_AT = 700;
    localparam int N_RAND   = 6;
`endif
    localparam int TMO = LAT + 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NC-1:0] data_in;
    logic          busy;
    logic          done;
    logic [NC-1:0] data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inv_permute_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    // Reference: inverse pi, in(x,y,z) -> out(row=(x+3y)%5, col=x, page=z).
    function automatic logic [NC-1:0] model_inv(input logic [NC-1:0] d);
        logic [NC-1:0] r;
        r = '0;
        for (int z = 0; z < 64; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    r[z*25 + x*5 + (x + 3*y) % 5] = d[z*25 + y*5 + x];
        return r;
    endfunction

    // Standard Keccak pi: A'[x][y] = A[(x+3y)%5][x].
    function automatic logic [NC-1:0] forward_pi(input logic [NC-1:0] d);
        logic [NC-1:0] r;
        r = '0;
        for (int z = 0; z < 64; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    r[z*25 + y*5 + x] = d[z*25 + x*5 + (x + 3*y) % 5];
        return r;
    endfunction

    function automatic logic [NC-1:0] rand_state();
        logic [NC-1:0] r;
        for (int i = 0; i < NC / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int diff_bits(input logic [NC-1:0] a, input logic [NC-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < NC; i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    function automatic int first_diff(input logic [NC-1:0] a, input logic [NC-1:0] b);
        for (int i = 0; i < NC; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // Drives one start pulse and collects timing/result observations.
    task automatic run_op(input logic [NC-1:0] d, input bit no_wait,
                          output logic [NC-1:0] first_q, output logic [NC-1:0] q,
                          output int busy_cnt, output int done_at, output logic extra_done);
        if (!no_wait) @(negedge clk);
        data_in = d;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        first_q  = data_out;
        busy_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= TMO; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        q = data_out;
        @(negedge clk);
        extra_done = done;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: %0d bits set, exp 0", diff_bits(data_out, '0)); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_bits();
        int in_bit [3]  = '{10, 6, 1599};
        int out_bit [3] = '{1, 9, 1596};
        logic [NC-1:0] d, exp_q, f, q;
        int bc, da;
        logic xd;
        for (int i = 0; i < 3; i++) begin
            d = '0; d[in_bit[i]] = 1'b1;
            exp_q = '0; exp_q[out_bit[i]] = 1'b1;
            run_op(d, 1'b0, f, q, bc, da, xd);
            checks++;
            if (q !== exp_q) begin
                errors++;
                $display("FAIL single_bit[%0d]: in bit %0d -> out first diff at %0d, exp only bit %0d set",
                         i, in_bit[i], first_diff(q, exp_q), out_bit[i]);
            end
            checks++;
            if (da !== LAT + 1) begin errors++; $display("FAIL single_bit_latency[%0d]: done at %0d exp %0d", i, da, LAT + 1); end
        end
    endtask

    task automatic test_random_roundtrip();
        logic [NC-1:0] d, fw, f, q;
        int bc, da;
        logic xd;
        for (int i = 0; i < N_RAND; i++) begin
            d  = rand_state();
            fw = forward_pi(d);
            run_op(fw, 1'b0, f, q, bc, da, xd);
            checks++;
            if (q !== d) begin
                errors++;
                $display("FAIL roundtrip[%0d]: %0d bits differ, first %0d", i, diff_bits(q, d), first_diff(q, d));
            end
            checks++;
            if (q !== model_inv(fw)) begin errors++; $display("FAIL model_inv[%0d]: %0d bits differ", i, diff_bits(q, model_inv(fw))); end
            checks++;
            if (bc !== LAT) begin errors++; $display("FAIL busy_len[%0d]: got %0d exp %0d", i, bc, LAT); end
            checks++;
            if (xd !== 1'b0) begin errors++; $display("FAIL done_width[%0d]: done still %b after one cycle, exp 0", i, xd); end
        end
    endtask

    task automatic test_start_ignored();
        logic [NC-1:0] d, fw, q;
        int dones, done_at, post_busy, post_done;
        d  = rand_state();
        fw = forward_pi(d);
        @(negedge clk);
        data_in = fw;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        dones   = 0;
        done_at = -1;
        for (int c = 1; c <= TMO; c++) begin
            start = (c == LAT / 2);
            if (done) begin
                dones++;
                done_at = c;
                start   = 1'b1;
                break;
            end
            @(negedge clk);
        end
        q = data_out;
        @(negedge clk);
        start     = 1'b0;
        post_busy = 0;
        post_done = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            if (busy) post_busy++;
            if (done) post_done++;
            @(negedge clk);
        end
        checks++; if (done_at !== LAT + 1) begin errors++; $display("FAIL ignore_latency: done at %0d exp %0d", done_at, LAT + 1); end
        checks++; if (q !== d) begin errors++; $display("FAIL ignore_result: %0d bits differ", diff_bits(q, d)); end
        checks++; if (post_busy !== 0) begin errors++; $display("FAIL ignore_no_restart: busy cycles %0d exp 0", post_busy); end
        checks++; if (post_done !== 0) begin errors++; $display("FAIL ignore_done_count: extra dones %0d exp 0", post_done); end
        checks++; if (data_out !== d) begin errors++; $display("FAIL ignore_hold: %0d bits differ", diff_bits(data_out, d)); end
    endtask

    task automatic test_reset_mid_run();
        logic [NC-1:0] d, fw, f, q;
        int bc, da, post_busy, post_done;
        logic xd;
        d  = rand_state();
        fw = forward_pi(d);
        @(negedge clk);
        data_in = fw;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ABORT_AT - 1) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b exp 0", done); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL abort_data_out: %0d bits set exp 0", diff_bits(data_out, '0)); end
        @(negedge clk);
        rst       = 1'b1;
        post_busy = 0;
        post_done = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            if (busy) post_busy++;
            if (done) post_done++;
            @(negedge clk);
        end
        checks++; if (post_done !== 0) begin errors++; $display("FAIL abort_no_done: dones %0d exp 0", post_done); end
        checks++; if (post_busy !== 0) begin errors++; $display("FAIL abort_idle: busy cycles %0d exp 0", post_busy); end
        run_op(fw, 1'b0, f, q, bc, da, xd);
        checks++; if (q !== d) begin errors++; $display("FAIL abort_rerun: %0d bits differ", diff_bits(q, d)); end
        checks++; if (da !== LAT + 1) begin errors++; $display("FAIL abort_rerun_latency: done at %0d exp %0d", da, LAT + 1); end
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0] d1, d2, f1, f2, q1, q2;
        int bc1, bc2, da1, da2;
        logic xd1, xd2;
        d1 = rand_state();
        d2 = rand_state();
        run_op(forward_pi(d1), 1'b0, f1, q1, bc1, da1, xd1);
        run_op(forward_pi(d2), 1'b1, f2, q2, bc2, da2, xd2);
        checks++; if (q1 !== d1) begin errors++; $display("FAIL b2b_first: %0d bits differ", diff_bits(q1, d1)); end
        checks++; if (f1 !== '0) begin errors++; $display("FAIL b2b_clear_first: %0d bits set exp 0", diff_bits(f1, '0)); end
        checks++; if (f2 !== '0) begin errors++; $display("FAIL b2b_clear_second: %0d bits set exp 0", diff_bits(f2, '0)); end
        checks++; if (q2 !== d2) begin errors++; $display("FAIL b2b_second: %0d bits differ", diff_bits(q2, d2)); end
        checks++; if (da2 !== LAT + 1) begin errors++; $display("FAIL b2b_latency: done at %0d exp %0d", da2, LAT + 1); end
        checks++; if (bc2 !== LAT) begin errors++; $display("FAIL b2b_busy_len: got %0d exp %0d", bc2, LAT); end
    endtask

    initial begin
        test_reset();
        test_single_bits();
        test_random_roundtrip();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
